// File: rtl/sha256_hit_detector.sv
// SHA-256 feed-forward and hit detection. The midstate is added to the final round state,
// nonces whose result word 7 is zero are queued in a first-word-fall-through FIFO, and hashes are counted.
module sha256_hit_detector #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [31:0] NONCE_OFFSET = 32'd0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [255:0] in_state,
  input  logic [31:0]  in_nonce,
  input  logic [255:0] midstate,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_nonce,
  output logic [31:0]  out_word6,
  output logic         overflow,
  output logic [31:0]  hash_count
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned NW = 8;

  typedef struct packed {
    logic [31:0] nonce;
    logic [31:0] word6;
  } hit_t;

  // vld_pipe_q[0]: stage-1 result valid, vld_pipe_q[1]: stage-2 result is a hit
  logic [1:0]          vld_pipe_q, vld_pipe_d;
  logic [NW-1:0][31:0] s1_sum_q, s1_sum_d;
  logic [31:0]         s1_nonce_q;
  hit_t                s2_q;

  hit_t                mem_q [FIFO_DEPTH];
  hit_t                hold_q, head;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [31:0]         hash_cnt_q, hash_cnt_d;
  logic                push, pop, full, push_ok;
  logic                unused_words;

  for (genvar w = 0; w < NW; w++) begin : g_ffwd
    assign s1_sum_d[w] = in_state[32*w +: 32] + midstate[32*w +: 32];
  end

  // Only words 6 and 7 leave the block; the rest are computed for completeness.
  assign unused_words = ^s1_sum_q[5:0];

  always_comb begin
    vld_pipe_d[0] = in_valid;
    vld_pipe_d[1] = vld_pipe_q[0] & (s1_sum_q[7] == 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) vld_pipe_q <= '0;
    else     vld_pipe_q <= vld_pipe_d;
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      s1_sum_q   <= s1_sum_d;
      s1_nonce_q <= in_nonce - NONCE_OFFSET;
    end
    s2_q <= '{nonce: s1_nonce_q, word6: s1_sum_q[6]};
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_valid = (cnt_q != '0);
  assign out_nonce = out_valid ? head.nonce : hold_q.nonce;
  assign out_word6 = out_valid ? head.word6 : hold_q.word6;
  assign overflow  = ovf_q;
  assign hash_count = hash_cnt_q;

  // A full FIFO still takes a push when the head leaves on the same edge.
  always_comb begin
    full       = (cnt_q == CW'(FIFO_DEPTH));
    pop        = out_valid & out_ready;
    push       = vld_pipe_q[1];
    push_ok    = push & (~full | pop);
    wr_ptr_d   = wr_ptr_q + AW'(push_ok);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    cnt_d      = cnt_q + CW'(push_ok) - CW'(pop);
    ovf_d      = ovf_q | (push & ~push_ok);
    hash_cnt_d = hash_cnt_q + 32'(in_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      hash_cnt_q <= '0;
      hold_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      hash_cnt_q <= hash_cnt_d;
      if (pop) hold_q <= head;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= s2_q;
  end

endmodule

// File: tb/tb_sha256_hit_detector.sv
// Randomized and directed bench for sha256_hit_detector: a queue-based reference model
// feeds an expected-hit queue that an independent monitor drains against the DUT.
module tb_sha256_hit_detector;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] OFS   = 32'd2;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready, out_valid, overflow;
  logic [255:0] in_state, midstate;
  logic [31:0]  in_nonce, out_nonce, out_word6, hash_count;

  always #5 clk = ~clk;

  sha256_hit_detector #(.FIFO_DEPTH(DEPTH), .NONCE_OFFSET(OFS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_state(in_state), .in_nonce(in_nonce),
    .midstate(midstate), .out_valid(out_valid), .out_ready(out_ready), .out_nonce(out_nonce),
    .out_word6(out_word6), .overflow(overflow), .hash_count(hash_count)
  );

  typedef struct { logic [31:0] n; logic [31:0] w6; int unsigned due; } pend_t;
  typedef struct { logic [31:0] n; logic [31:0] w6; } exp_t;

  int unsigned n_chk = 0, n_pass = 0;
  pend_t       pend[$];
  exp_t        exp_q[$];
  int unsigned edge_no = 0, mocc = 0;
  logic [31:0] mcnt = '0;
  bit          movf = 1'b0, mon_en = 1'b0;
  exp_t        last, e;
  pend_t       m_p;
  logic [31:0] m_sum7;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
  endtask

  // Reference model: hits land in the FIFO two edges after the accepting edge.
  always @(posedge clk) begin
    edge_no++;
    if (rst) begin
      pend.delete(); exp_q.delete();
      mocc = 0; mcnt = '0; movf = 1'b0; last = '{32'd0, 32'd0};
    end else begin
      if (mocc > 0 && out_ready) mocc--;
      if (pend.size() > 0 && pend[0].due == edge_no) begin
        m_p = pend.pop_front();
        if (mocc < DEPTH) begin
          exp_q.push_back('{m_p.n, m_p.w6});
          mocc++;
        end else movf = 1'b1;
      end
      if (in_valid) begin
        mcnt++;
        m_sum7 = in_state[255:224] + midstate[255:224];
        if (m_sum7 == 32'd0)
          pend.push_back('{in_nonce - OFS, in_state[223:192] + midstate[223:192], edge_no + 2});
      end
    end
  end

  // Monitor: samples mid-cycle, after the driver has settled the inputs.
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      check("out_valid", 32'(out_valid), 32'(mocc != 0));
      check("overflow", 32'(overflow), 32'(movf));
      check("hash_count", hash_count, mcnt);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_hit: got nonce %h expected no entry", out_nonce);
        end else begin
          e = exp_q[0];
          check("head_nonce", out_nonce, e.n);
          check("head_word6", out_word6, e.w6);
          if (out_ready) begin
            void'(exp_q.pop_front());
            last = e;
          end
        end
      end else begin
        check("hold_nonce", out_nonce, last.n);
        check("hold_word6", out_word6, last.w6);
      end
    end
  end

  task automatic drive(input bit v, input logic [255:0] st, input logic [31:0] n,
                       input bit rdy, input bit r);
    @(negedge clk);
    in_valid = v; in_state = st; in_nonce = n; out_ready = rdy; rst = r;
  endtask

  function automatic logic [255:0] mk_state(input bit hit);
    logic [255:0] st;
    logic [31:0]  s7;
    for (int w = 0; w < 8; w++) st[32*w +: 32] = $urandom;
    s7 = hit ? 32'd0 : ($urandom | 32'd1);
    st[255:224] = s7 - midstate[255:224];
    return st;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_state = '0; in_nonce = '0; out_ready = 1'b0;
    midstate = {8{32'h0000_0001}};
    drive(0, '0, 0, 0, 1);
    drive(0, '0, 0, 0, 1);
    mon_en = 1'b1;
    drive(0, '0, 0, 1, 0);

    // feed-forward: word7 0xFFFFFFFF + 1 wraps to zero, word6 0 + 1
    drive(1, {32'hFFFF_FFFF, 224'd0}, 32'h100, 1, 0);
    repeat (4) drive(0, '0, 0, 1, 0);

    // non-hit burst: word7 sum is 1
    for (int i = 0; i < 10; i++) drive(1, {32'h0000_0000, 224'd0} | 256'(i), 32'(i), 1, 0);
    repeat (3) drive(0, '0, 0, 1, 0);

    // offset wrap: nonce 1 - 2
    drive(1, mk_state(1), 32'h1, 1, 0);
    repeat (4) drive(0, '0, 0, 1, 0);

    // overflow: five hits into a four-entry FIFO with no consumer
    for (int i = 1; i <= 5; i++) drive(1, mk_state(1), 32'(i), 0, 0);
    repeat (4) drive(0, '0, 0, 0, 0);
    repeat (6) drive(0, '0, 0, 1, 0);
    drive(0, '0, 0, 0, 1);

    // full FIFO with simultaneous push and pop
    for (int i = 1; i <= 4; i++) drive(1, mk_state(1), 32'(i), 0, 0);
    drive(1, mk_state(1), 32'd9, 0, 0);
    drive(0, '0, 0, 0, 0);
    drive(0, '0, 0, 1, 0);
    repeat (3) drive(0, '0, 0, 0, 0);
    repeat (6) drive(0, '0, 0, 1, 0);

    // reset one edge after a hit is accepted; in_valid during reset is ignored
    drive(1, mk_state(1), 32'h55, 1, 0);
    drive(1, mk_state(1), 32'h56, 1, 1);
    repeat (5) drive(0, '0, 0, 1, 0);

    // randomized traffic with a fresh midstate
    for (int w = 0; w < 8; w++) midstate[32*w +: 32] = $urandom;
    for (int i = 0; i < 400; i++)
      drive(($urandom % 4) != 0, mk_state(($urandom % 3) == 0), $urandom,
            ($urandom % 2) == 0, ($urandom % 150) == 0);
    repeat (10) drive(0, '0, 0, 1, 0);

    // counter wrap from a forced all-ones count
    force dut.hash_cnt_q = 32'hFFFF_FFFF;
    mcnt = 32'hFFFF_FFFF;
    drive(0, '0, 0, 1, 0);
    release dut.hash_cnt_q;
    drive(1, mk_state(0), 32'h7, 1, 0);
    repeat (3) drive(0, '0, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
